// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO and its storage array.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Pointer width for a given depth; never narrower than one bit.
  function automatic int addr_width(input int depth);
    if (depth <= 2) begin
      return 1;
    end
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_storage.sv
// Simple dual-port array: synchronous write port, registered read port.
// The read register is the FIFO's data_out, so it is the only part that resets.
module fifo_storage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; a same-address write in the same cycle returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/param_fifo.sv
// Parameterised single-clock FIFO: pointers, occupancy count, status flags,
// sticky error flags and synchronous clear around an inferred dual-port array.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int DEPTH              = DEFAULT_DEPTH,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  localparam int ADDR_WIDTH        = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  clear,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = ALMOST_EMPTY_LEVEL[ADDR_WIDTH:0];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Strobe semantics: write_enable/read_enable are single-cycle requests with
  // no back-pressure handshake. A write is accepted when the FIFO is not full,
  // or when it is full but a read is accepted in the same cycle; a read is
  // accepted when the FIFO is not empty. Rejected requests are dropped and
  // latch overflow/underflow. clear overrides both strobes for its cycle.
  always_comb begin
    rd_acc = read_enable && !empty && !clear;
    wr_acc = write_enable && (!full || rd_acc) && !clear;
  end

  // Status flags derive only from the occupancy count.
  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
  end

  // Pointers, occupancy, read-valid strobe and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
      data_valid <= rd_acc;
      if (write_enable && !wr_acc) begin
        overflow <= 1'b1;
      end
      if (read_enable && !rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end

  fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parameterised synchronous FIFO built around an inferred dual-pointer memory array, with one clock domain.
It generalises the single-port parameterised memory into a buffered queue:
- independent write and read strobes
- occupancy count and full/empty/almost flags
- sticky overflow/underflow error flags with synchronous clear

It sits between producer and consumer blocks that run on the same clk.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out in bits
DEPTH, 16, number of entries; must be a power of two, >= 2
ALMOST_FULL_LEVEL, DEPTH-2, almost_full asserts when count >= this value
ALMOST_EMPTY_LEVEL, 2, almost_empty asserts when count <= this value
(derived localparam) ADDR_WIDTH = $clog2(DEPTH); count is ADDR_WIDTH+1 bits

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; asynchronous, active-low
write_enable  input  1  push request
data_in  input  DATA_WIDTH  push data
read_enable  input  1  pop request
data_out  output  DATA_WIDTH  registered pop data
data_valid  output  1  data_out holds a newly popped word this cycle
clear  input  1  synchronous flush of contents and error flags
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= ALMOST_FULL_LEVEL
almost_empty  output  1  count <= ALMOST_EMPTY_LEVEL
count  output  ADDR_WIDTH+1  current occupancy
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (rst_n low, asynchronous): pointers, count, data_out, data_valid, overflow and underflow all go to 0. empty=1, almost_empty=1, full=0, almost_full=0. Memory contents are not reset.
- Write accepted: write_enable && (!full || read accepted same cycle). The word is stored at wr_ptr and wr_ptr increments mod DEPTH.
- Read accepted: read_enable && !empty. data_out <= mem[rd_ptr] at the clock edge; rd_ptr increments mod DEPTH.
- Read latency is 1 cycle. data_valid is high for exactly the cycle after each accepted read, otherwise 0. data_out holds its last value when no read is accepted.
- Count: +1 on write only, -1 on read only, unchanged on both or neither. All flags are combinational from count.
- Full and both strobes asserted: both are accepted, count stays DEPTH, no overflow.
- Empty and both strobes asserted: write accepted, read rejected, underflow set, count becomes 1. The read never returns the word being written in that cycle.
- Rejected write (full, no read): data is discarded and overflow is set.
- Rejected read (empty): data_out is unchanged, data_valid=0, underflow is set.
- Flags are sticky; only clear or reset drops them.
- clear (synchronous, dominates strobes): pointers, count, data_valid, overflow and underflow go to 0 next edge. data_out is held. Strobes in the clear cycle are ignored and set no error flag.
- Pointer wrap: pointers are ADDR_WIDTH bits and roll over DEPTH-1 -> 0 naturally. Full/empty come from count, never from pointer compare.
- Reset asserted mid-operation: immediate asynchronous return to the reset state. The first accepted write after release lands at address 0.

Decomposition:
- Shared package fifo_pkg holds:
  - default constants DEFAULT_DATA_WIDTH=8 and DEFAULT_DEPTH=16
  - a clog2-based ADDR_WIDTH helper
- One natural sub-module, fifo_storage: a simple dual-port array with synchronous write and registered read, parameterised by DATA_WIDTH/DEPTH.
- param_fifo holds the pointers, count, flags and control logic.

Test Plan:
- DEPTH=4, after reset: push 8'd45, 8'd77, 8'd32 on consecutive cycles -> count=3, almost_full=1 (level 2), empty=0.
- Pop three times -> data_out 45, 77, 32 on successive cycles, each with data_valid=1 one cycle after read_enable; then empty=1, count=0.
- Fill DEPTH=4 with 1,2,3,4, then push 5 -> full stays 1, overflow=1, count=4. Popping four times returns 1,2,3,4 (5 dropped).
- Empty FIFO, read_enable alone -> underflow=1, data_valid=0, data_out unchanged. Then pulse clear -> overflow=0, underflow=0.
- Full FIFO, write 8'd12 and read in the same cycle -> data_out=oldest word, count stays 4, no overflow. Keep streaming 10 more words -> pointers wrap and order is preserved.
- Mid-stream with count=3, pulse rst_n low between clock edges -> outputs go to reset values immediately. After release, push 8'd20 then pop -> data_out=20.
